// File: rtl/jtcps1_gfx_pkg.sv
// Shared constants for the CPS1 GFX mapper arbiter: layer codes,
// ROM address field widths, FSM state type and the bank-merge helper.
package jtcps1_gfx_pkg;

    localparam logic [2:0] OBJ   = 3'd0;
    localparam logic [2:0] SCR1  = 3'd1;
    localparam logic [2:0] SCR2  = 3'd2;
    localparam logic [2:0] SCR3  = 3'd3;
    localparam logic [2:0] STARS = 3'd4;

    localparam int LAYW  = 3;
    localparam int BANKW = 4;
    localparam int CODEW = 12;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESOLVE,
        DONE
    } arb_state_t;

    // Bits selected by mask come from the tile code, the rest from offset
    function automatic logic [3:0] map_bank(
        input logic [3:0] hi,
        input logic [3:0] offset,
        input logic [3:0] mask
    );
        return (hi & mask) | (offset & ~mask);
    endfunction

endpackage

// File: rtl/jtcps1_gfx_map_arb_if.sv
// Fetcher-side request bus plus the mapper lookup bus.
// slave: arbiter view; master: fetchers + mapper (testbench) view.
interface jtcps1_gfx_map_arb_if #(
    parameter int NREQ = 5,
    parameter int SUBW = 4
);
    import jtcps1_gfx_pkg::*;

    localparam int AW = LAYW + BANKW + CODEW + SUBW;

    logic [NREQ-1:0]      req;
    logic [NREQ*16-1:0]   code;
    logic [NREQ*SUBW-1:0] sub;
    logic [NREQ-1:0]      ack;
    logic [AW-1:0]        rom_addr;
    logic                 blank;

    logic                 map_en;
    logic [2:0]           map_layer;
    logic [9:0]           map_cin;
    logic [3:0]           map_offset;
    logic [3:0]           map_mask;
    logic                 map_unmap;

    modport slave (
        input  req, code, sub,
        input  map_offset, map_mask, map_unmap,
        output ack, rom_addr, blank,
        output map_en, map_layer, map_cin
    );

    modport master (
        output req, code, sub,
        output map_offset, map_mask, map_unmap,
        input  ack, rom_addr, blank,
        input  map_en, map_layer, map_cin
    );

endinterface

// File: rtl/jtcps1_rr_pick.sv
// Round-robin picker: first set req bit at or after rr_ptr, wrapping.
// Ports: req (NREQ), rr_ptr -> idx (granted index), any (some req set).
module jtcps1_rr_pick #(
    parameter int NREQ = 5,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            // an out-of-range pointer must never yield an index >= NREQ
            if (j < NREQ && !any && req[j[IW-1:0]]) begin
                any = 1'b1;
                idx = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/jtcps1_gfx_map_arb.sv
// Shares one GFX mapper among the layer fetchers and builds ROM addresses.
// Ports: clk, rst (async, high); bus (slave): req/code/sub -> ack/rom_addr/blank,
// map_en/map_layer/map_cin -> mapper, map_offset/map_mask/map_unmap <- mapper.
module jtcps1_gfx_map_arb
    import jtcps1_gfx_pkg::*;
#(
    parameter int NREQ = 5,
    parameter int SUBW = 4
) (
    input  logic                clk,
    input  logic                rst,
    jtcps1_gfx_map_arb_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state, state_nx;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [15:0]      code_q;
    logic [SUBW-1:0]  sub_q;

    jtcps1_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_any) state_nx = LOOKUP;
            LOOKUP:  state_nx = RESOLVE;
            RESOLVE: state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // the mapper registers its bank on the edge closing LOOKUP
    assign bus.map_en = (state == LOOKUP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            idx           <= '0;
            code_q        <= '0;
            sub_q         <= '0;
            bus.ack       <= '0;
            bus.rom_addr  <= '0;
            bus.blank     <= 1'b0;
            bus.map_layer <= '0;
            bus.map_cin   <= '0;
        end else begin
            bus.ack <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        idx           <= pick_idx;
                        code_q        <= bus.code[16*pick_idx +: 16];
                        sub_q         <= bus.sub[SUBW*pick_idx +: SUBW];
                        bus.map_layer <= 3'(pick_idx);
                        bus.map_cin   <= bus.code[16*pick_idx+6 +: 10];
                    end
                end
                RESOLVE: begin
                    bus.rom_addr <= {3'(idx),
                                     map_bank(code_q[15:12],
                                              bus.map_offset,
                                              bus.map_mask),
                                     code_q[11:0], sub_q};
                    bus.blank    <= bus.map_unmap;
                    bus.ack      <= NREQ'(1) << idx;
                end
                DONE: begin
                    rr_ptr <= (idx == IW'(NREQ-1)) ? '0 : idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcps1_gfx_map_arb.sv
// Self-checking bench for jtcps1_gfx_map_arb: transaction-level model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_jtcps1_gfx_map_arb;
    import jtcps1_gfx_pkg::*;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtcps1_gfx_map_arb_if #(.NREQ(N), .SUBW(4)) bus ();

    jtcps1_gfx_map_arb #(.NREQ(N), .SUBW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // mapper stand-in: per-layer {unmap, mask, offset}, latched on map_en
    logic [8:0] lut [0:7];
    logic [8:0] mreg = '0;
    always @(posedge clk) if (bus.map_en) mreg <= lut[bus.map_layer];
    assign bus.map_offset = mreg[3:0];
    assign bus.map_mask   = mreg[7:4];
    assign bus.map_unmap  = mreg[8];

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction schedule) -------------
    int          cyc      = 0;
    int          next_free = 0;
    int          rr       = 0;
    int          en_cyc   = -10;
    int          ack_cyc  = -10;
    int          g_idx    = 0;
    logic [9:0]  g_cin;
    logic [22:0] pend_addr, exp_addr;
    logic        pend_blank, exp_blank;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            next_free = 0;
            rr        = 0;
            en_cyc    = -10;
            ack_cyc   = -10;
            exp_addr  = '0;
            exp_blank = 1'b0;
        end else begin
            int g;
            logic [15:0] c;
            logic [3:0]  s, bank;
            logic [8:0]  m;
            cyc++;
            if (cyc == ack_cyc) begin
                exp_addr  = pend_addr;
                exp_blank = pend_blank;
            end
            if (cyc >= next_free && bus.req != '0) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && bus.req[(rr+k)%N]) g = (rr + k) % N;
                c    = bus.code[16*g +: 16];
                s    = bus.sub[4*g +: 4];
                m    = lut[g];
                bank = (c[15:12] & m[7:4]) | (m[3:0] & ~m[7:4]);
                pend_addr  = {3'(g), bank, c[11:0], s};
                pend_blank = m[8];
                g_idx     = g;
                g_cin     = c[15:6];
                en_cyc    = cyc;
                ack_cyc   = cyc + 2;
                next_free = cyc + 4;
                rr        = (g + 1) % N;
            end
        end
    end

    // ---------------- per-cycle compare --------------------------------------
    int ack_idx_q[$];
    int ack_cyc_q[$];
    int en_count = 0;

    always @(negedge clk) begin
        if (!rst) begin
            logic [N-1:0] ea;
            ea = (cyc == ack_cyc) ? N'(1) << g_idx : '0;
            chk("map_en", 32'(bus.map_en), 32'(cyc == en_cyc));
            chk("ack", 32'(bus.ack), 32'(ea));
            chk("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
            chk("blank", 32'(bus.blank), 32'(exp_blank));
            if (cyc == en_cyc) begin
                chk("map_layer", 32'(bus.map_layer), 32'(g_idx));
                chk("map_cin", 32'(bus.map_cin), 32'(g_cin));
            end
            if (bus.map_en) en_count++;
            for (int i = 0; i < N; i++)
                if (bus.ack[i]) begin
                    ack_idx_q.push_back(i);
                    ack_cyc_q.push_back(cyc);
                end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic set_req(input int i, input logic [15:0] c,
                           input logic [3:0] s);
        bus.code[16*i +: 16] = c;
        bus.sub[4*i +: 4]    = s;
        bus.req[i]           = 1'b1;
    endtask

    task automatic clear_log();
        ack_idx_q.delete();
        ack_cyc_q.delete();
    endtask

    // wait (bounded) until n acks logged; optionally drop acked requests
    task automatic run_until(input int n, input int budget, input bit drop);
        int b;
        b = 0;
        while (ack_idx_q.size() < n && b < budget) begin
            @(negedge clk);
            #1;
            if (drop) bus.req = bus.req & ~bus.ack;
            b++;
        end
        chk("ack_count", 32'(ack_idx_q.size()), 32'(n));
    endtask

    task automatic wait_en(input int budget);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            #1;
            b++;
        end while (!bus.map_en && b < budget);
        chk("map_en_seen", 32'(bus.map_en), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0, n1;
        bus.req  = '0;
        bus.code = '0;
        bus.sub  = '0;
        for (int i = 0; i < 8; i++) lut[i] = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_blank", 32'(bus.blank), 32'd0);
        chk("rst_en", 32'(bus.map_en), 32'd0);
        chk("rst_layer", 32'(bus.map_layer), 32'd0);
        chk("rst_cin", 32'(bus.map_cin), 32'd0);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_en", 32'(en_count), 32'd0);

        // all five held: strict rotation from 0, one grant per 4 cycles
        for (int i = 0; i < 8; i++) lut[i] = 9'($urandom);
        for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 4'($urandom));
        clear_log();
        n1 = en_count;
        run_until(6, 40, 1'b0);
        bus.req = '0;
        for (int k = 0; k < 6 && k < ack_idx_q.size(); k++) begin
            chk("t2_order", 32'(ack_idx_q[k]), 32'(k % N));
            if (k > 0)
                chk("t2_spacing", 32'(ack_cyc_q[k] - ack_cyc_q[k-1]), 32'd4);
        end
        chk("t2_en_pulses", 32'(en_count - n1), 32'd6);
        repeat (4) @(negedge clk);

        // single SCR2 request, hand-computed address
        lut[SCR2] = {1'b0, 4'h3, 4'h8};
        set_req(2, 16'h5A3C, 4'h7);
        t0 = cyc;
        clear_log();
        run_until(1, 10, 1'b1);
        if (ack_idx_q.size() > 0) begin
            chk("t1_latency", 32'(ack_cyc_q[0] - t0), 32'd3);
            chk("t1_idx", 32'(ack_idx_q[0]), 32'd2);
        end
        repeat (3) @(negedge clk);
        chk("t1_addr", 32'(bus.rom_addr), 32'({3'd2, 4'h9, 12'hA3C, 4'h7}));
        chk("t1_blank", 32'(bus.blank), 32'd0);

        // STARS grant wraps the pointer to 0: then 0 before 4
        set_req(4, 16'($urandom), 4'($urandom));
        clear_log();
        run_until(1, 10, 1'b1);
        repeat (2) @(negedge clk);
        set_req(0, 16'($urandom), 4'($urandom));
        set_req(4, 16'($urandom), 4'($urandom));
        clear_log();
        run_until(2, 20, 1'b1);
        if (ack_idx_q.size() > 1) begin
            chk("t3_first", 32'(ack_idx_q[0]), 32'd0);
            chk("t3_second", 32'(ack_idx_q[1]), 32'd4);
        end
        repeat (3) @(negedge clk);

        // unmapped OBJ tile: blank, mask F passes the code nibble
        lut[OBJ] = {1'b1, 4'hF, 4'h0};
        set_req(0, 16'hFFC0, 4'h2);
        clear_log();
        run_until(1, 10, 1'b1);
        repeat (2) @(negedge clk);
        chk("t4_addr", 32'(bus.rom_addr), 32'({3'd0, 4'hF, 12'hFC0, 4'h2}));
        chk("t4_blank", 32'(bus.blank), 32'd1);

        // reset during LOOKUP of SCR3 (pointer is 1), then restart from 0
        set_req(0, 16'($urandom), 4'($urandom));
        set_req(3, 16'($urandom), 4'($urandom));
        wait_en(10);
        chk("t5_layer", 32'(bus.map_layer), 32'd3);
        rst = 1'b1;
        #1;
        chk("t5_ack", 32'(bus.ack), 32'd0);
        chk("t5_addr", 32'(bus.rom_addr), 32'd0);
        chk("t5_blank", 32'(bus.blank), 32'd0);
        chk("t5_en", 32'(bus.map_en), 32'd0);
        chk("t5_layer0", 32'(bus.map_layer), 32'd0);
        chk("t5_cin", 32'(bus.map_cin), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        clear_log();
        run_until(1, 10, 1'b1);
        if (ack_idx_q.size() > 0)
            chk("t5_regrant", 32'(ack_idx_q[0]), 32'd0);
        run_until(2, 10, 1'b1);
        repeat (2) @(negedge clk);

        // SCR1 drops its request in RESOLVE: one ack, no re-grant
        set_req(1, 16'($urandom), 4'($urandom));
        clear_log();
        wait_en(10);
        @(negedge clk);
        #1 bus.req[1] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_acks", 32'(ack_idx_q.size()), 32'd1);
        if (ack_idx_q.size() > 0)
            chk("t6_idx", 32'(ack_idx_q[0]), 32'd1);

        // randomized traffic
        for (int r = 0; r < 3; r++) begin
            repeat (6) @(negedge clk);
            for (int i = 0; i < 8; i++) lut[i] = 9'($urandom);
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                #1;
                for (int i = 0; i < N; i++) begin
                    if (bus.ack[i])
                        bus.req[i] = 1'b0;
                    else if (!bus.req[i] && $urandom_range(0, 2) == 0)
                        set_req(i, 16'($urandom), 4'($urandom));
                end
            end
            for (int c = 0; c < 60 && bus.req != '0; c++) begin
                @(negedge clk);
                #1 bus.req = bus.req & ~bus.ack;
            end
            chk("drain", 32'(bus.req), 32'd0);
        end

        repeat (6) @(negedge clk);
        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
